audio_stream_bridge: RTL and testbench
======================================

Name: audio_stream_bridge

Overview:
- Parametrised, buffered bridge between the audio codec's per-channel ADC/DAC valid-ready streams and per-channel processing cores.
- Each channel has an RX FIFO (ADC to core) and a TX FIFO (core to DAC).
- Per-channel modes: ADC-to-DAC bypass and DAC mute.
- Sticky overrun/underrun status flags and a DAC sample counter for debug LEDs.
- Sits in the processor top level between the codec audio interface and the cores.

Parameters:
NUM_CH, 2, number of audio channels (index 0 = left, 1 = right).
DATA_W, 32, sample width in bits.
FIFO_DEPTH, 4, entries per FIFO; power of two, 2 or more.
CNT_W, 16, width of the DAC sample counter.

Ports:
clock  in  1  system clock (CLOCK_50 domain).
reset  in  1  asynchronous, active-high reset.
adc_data  in  NUM_CH*DATA_W  codec ADC samples, channel c at bits [c*DATA_W +: DATA_W].
adc_valid  in  NUM_CH  ADC sample valid, per channel.
adc_ready  out  NUM_CH  bridge accepts ADC sample.
core_rx_data  out  NUM_CH*DATA_W  sample presented to core.
core_rx_valid  out  NUM_CH  core_rx_data valid.
core_rx_ready  in  NUM_CH  core consumes sample.
core_tx_data  in  NUM_CH*DATA_W  processed sample from core.
core_tx_valid  in  NUM_CH  core_tx_data valid.
core_tx_ready  out  NUM_CH  bridge accepts core sample.
dac_data  out  NUM_CH*DATA_W  sample to codec DAC.
dac_valid  out  NUM_CH  dac_data valid.
dac_ready  in  NUM_CH  codec DAC accepts sample.
bypass  in  NUM_CH  per-channel bypass mode.
mute  in  NUM_CH  per-channel DAC mute.
clear_status  in  1  single-cycle pulse; clears sticky flags and counter.
overrun  out  NUM_CH  sticky: ADC offered a sample while RX FIFO was full.
underrun  out  NUM_CH  sticky: DAC requested while TX FIFO was empty.
dac_count  out  CNT_W  samples accepted by DAC on channel 0.

Behaviour:
- Reset (asynchronous, active-high):
  - All FIFOs empty; pointers and occupancy counts zeroed.
  - Registered bypass_q/mute_q = 0; overrun = underrun = 0; dac_count = 0.
  - Outputs therefore: adc_ready = all 1, core_tx_ready = all 1, core_rx_valid = 0, dac_valid = 0.
  - Reset mid-transfer discards buffered samples; no partial handshake survives.
- FIFOs:
  - Show-ahead; data output taken from the head entry; occupancy count 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
  - Push is accepted only when not full; a pop in the same cycle does not free a slot for that push.
  - Simultaneous push and pop when neither full nor empty leaves the count unchanged.
  - Write-to-read latency is 1 cycle: a sample accepted in cycle N is visible at the output in cycle N+1.
- RX path, channel c:
  - adc_ready[c] = !rx_full[c].
  - Push on adc_valid & adc_ready.
  - RX head is valid whenever !rx_empty.
- TX path, channel c:
  - dac_valid[c] = !tx_empty[c].
  - dac_data = mute_q[c] ? 0 : TX head.
  - Pop on dac_valid & dac_ready. Muted samples still pop.
- Mode control:
  - bypass and mute are registered (1-cycle delay) into bypass_q/mute_q before use.
- Normal mode (bypass_q[c]=0):
  - core_rx_valid = !rx_empty; core_rx_data = RX head; RX pops on core_rx_valid & core_rx_ready.
  - core_tx_ready = !tx_full; TX pushes core_tx_data on core_tx_valid & core_tx_ready.
- Bypass mode (bypass_q[c]=1):
  - core_rx_valid = 0 and core_tx_ready = 0.
  - RX head moves to the TX FIFO when !rx_empty & !tx_full; pops RX and pushes TX in the same cycle.
  - Minimum ADC-to-dac_valid latency is 2 cycles.
  - A mode change takes effect on the cycle after registration. Buffered samples are kept and drained in the new mode.
- Status flags:
  - overrun[c] sets when adc_valid[c] & rx_full[c].
  - underrun[c] sets when dac_ready[c] & tx_empty[c].
  - Both hold until clear_status. If set and clear occur in the same cycle, set wins.
- dac_count:
  - Increments on each channel-0 DAC pop and wraps at 2^CNT_W-1 to 0.
  - clear_status zeroes it. If clear and increment occur in the same cycle, the result is 1.
- No combinational path from any ready input to any valid output.

Test Plan:
- Reset, then bypass=0: drive ADC ch0 samples 0x11, 0x22, 0x33 with core_rx_ready=1 -> core_rx_data shows 0x11, 0x22, 0x33 in order, each 1 cycle after acceptance; adc_ready stays 1.
- Fill, FIFO_DEPTH=4, core_rx_ready=0: push 4 samples -> adc_ready[0]=0. Hold adc_valid for one more cycle -> overrun[0]=1. Pop one -> adc_ready returns to 1; overrun stays 1 until clear_status.
- Bypass ch1: drive ADC sample 0xABCD with dac_ready=1 -> dac_valid[1] asserts 2 cycles after acceptance with dac_data=0xABCD; core_rx_valid[1] remains 0 throughout.
- Mute ch0 with the TX FIFO holding 0x55: dac_data reads 0 and dac_valid=1; after the pop, dac_count increments by 1.
- Underrun and clear: assert dac_ready[0] with the TX FIFO empty -> underrun[0]=1. Pulse clear_status and the underrun condition in the same cycle -> underrun stays 1. Pulse clear_status alone -> underrun=0.
- Counter and async reset: preload the counter to 0xFFFF via pops, then pop once more -> dac_count=0x0000. Assert reset asynchronously mid-stream -> all FIFOs empty, flags 0, and dac_valid=0 immediately.

Source files
------------

// File: rtl/audio_stream_bridge.sv
// Buffered valid/ready bridge between codec ADC/DAC streams and per-channel cores,
// with per-channel bypass/mute, sticky overrun/underrun flags and a DAC sample counter.
module audio_stream_bridge #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] adc_data,
  input  logic [NUM_CH-1:0]        adc_valid,
  output logic [NUM_CH-1:0]        adc_ready,
  output logic [NUM_CH*DATA_W-1:0] core_rx_data,
  output logic [NUM_CH-1:0]        core_rx_valid,
  input  logic [NUM_CH-1:0]        core_rx_ready,
  input  logic [NUM_CH*DATA_W-1:0] core_tx_data,
  input  logic [NUM_CH-1:0]        core_tx_valid,
  output logic [NUM_CH-1:0]        core_tx_ready,
  output logic [NUM_CH*DATA_W-1:0] dac_data,
  output logic [NUM_CH-1:0]        dac_valid,
  input  logic [NUM_CH-1:0]        dac_ready,
  input  logic [NUM_CH-1:0]        bypass,
  input  logic [NUM_CH-1:0]        mute,
  input  logic                     clear_status,
  output logic [NUM_CH-1:0]        overrun,
  output logic [NUM_CH-1:0]        underrun,
  output logic [CNT_W-1:0]         dac_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL_CNT = OW'(FIFO_DEPTH);

  logic [NUM_CH-1:0] bypass_q;
  logic [NUM_CH-1:0] mute_q;
  logic [NUM_CH-1:0] rx_full_v;
  logic [NUM_CH-1:0] tx_empty_v;
  logic [NUM_CH-1:0] tx_pop_v;

  // Mode inputs are registered before they steer any datapath
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bypass_q <= '0;
      mute_q   <= '0;
    end else begin
      bypass_q <= bypass;
      mute_q   <= mute;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]     rx_wr, rx_rd, tx_wr, tx_rd;
    logic [OW-1:0]     rx_cnt, tx_cnt;
    logic              rx_full, rx_empty, rx_push, rx_pop;
    logic              tx_full, tx_empty, tx_push, tx_pop;
    logic              move;
    logic [DATA_W-1:0] rx_head, tx_head, tx_din;

    assign rx_full  = (rx_cnt == FULL_CNT);
    assign rx_empty = (rx_cnt == '0);
    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign rx_head  = rx_mem[rx_rd];
    assign tx_head  = tx_mem[tx_rd];

    // Bypass forwards the RX head straight into the TX FIFO in one cycle
    assign move    = bypass_q[c] & ~rx_empty & ~tx_full;
    assign rx_push = adc_valid[c] & ~rx_full;
    assign rx_pop  = bypass_q[c] ? move : (~rx_empty & core_rx_ready[c]);
    assign tx_push = bypass_q[c] ? move : (core_tx_valid[c] & ~tx_full);
    assign tx_din  = bypass_q[c] ? rx_head : core_tx_data[c*DATA_W +: DATA_W];
    assign tx_pop  = ~tx_empty & dac_ready[c];

    assign adc_ready[c]                    = ~rx_full;
    assign core_rx_valid[c]                = ~bypass_q[c] & ~rx_empty;
    assign core_rx_data[c*DATA_W +: DATA_W] = rx_head;
    assign core_tx_ready[c]                = ~bypass_q[c] & ~tx_full;
    assign dac_valid[c]                    = ~tx_empty;
    assign dac_data[c*DATA_W +: DATA_W]    = mute_q[c] ? '0 : tx_head;

    assign rx_full_v[c]  = rx_full;
    assign tx_empty_v[c] = tx_empty;
    assign tx_pop_v[c]   = tx_pop;

    always_ff @(posedge clock) begin
      if (rx_push) rx_mem[rx_wr] <= adc_data[c*DATA_W +: DATA_W];
      if (tx_push) tx_mem[tx_wr] <= tx_din;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        rx_wr  <= '0;
        rx_rd  <= '0;
        rx_cnt <= '0;
        tx_wr  <= '0;
        tx_rd  <= '0;
        tx_cnt <= '0;
      end else begin
        if (rx_push) rx_wr <= rx_wr + AW'(1);
        if (rx_pop)  rx_rd <= rx_rd + AW'(1);
        case ({rx_push, rx_pop})
          2'b10:   rx_cnt <= rx_cnt + OW'(1);
          2'b01:   rx_cnt <= rx_cnt - OW'(1);
          default: rx_cnt <= rx_cnt;
        endcase
        if (tx_push) tx_wr <= tx_wr + AW'(1);
        if (tx_pop)  tx_rd <= tx_rd + AW'(1);
        case ({tx_push, tx_pop})
          2'b10:   tx_cnt <= tx_cnt + OW'(1);
          2'b01:   tx_cnt <= tx_cnt - OW'(1);
          default: tx_cnt <= tx_cnt;
        endcase
      end
    end
  end

  // Sticky flags: a new event in the clearing cycle survives the clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun   <= '0;
      underrun  <= '0;
      dac_count <= '0;
    end else begin
      overrun  <= (clear_status ? '0 : overrun)  | (adc_valid & rx_full_v);
      underrun <= (clear_status ? '0 : underrun) | (dac_ready & tx_empty_v);
      if (clear_status)
        dac_count <= tx_pop_v[0] ? CNT_W'(1) : '0;
      else if (tx_pop_v[0])
        dac_count <= dac_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_audio_stream_bridge.sv
// Directed bench for audio_stream_bridge: RX/TX flow, bypass, mute, flags, counter wrap, async reset.
module tb_audio_stream_bridge;
  localparam int NUM_CH = 2;
  localparam int DATA_W = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W = 16;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [NUM_CH*DATA_W-1:0] adc_data;
  logic [NUM_CH-1:0]        adc_valid;
  logic [NUM_CH-1:0]        adc_ready;
  logic [NUM_CH*DATA_W-1:0] core_rx_data;
  logic [NUM_CH-1:0]        core_rx_valid;
  logic [NUM_CH-1:0]        core_rx_ready;
  logic [NUM_CH*DATA_W-1:0] core_tx_data;
  logic [NUM_CH-1:0]        core_tx_valid;
  logic [NUM_CH-1:0]        core_tx_ready;
  logic [NUM_CH*DATA_W-1:0] dac_data;
  logic [NUM_CH-1:0]        dac_valid;
  logic [NUM_CH-1:0]        dac_ready;
  logic [NUM_CH-1:0]        bypass;
  logic [NUM_CH-1:0]        mute;
  logic                     clear_status;
  logic [NUM_CH-1:0]        overrun;
  logic [NUM_CH-1:0]        underrun;
  logic [CNT_W-1:0]         dac_count;

  int checks = 0;
  int failures = 0;

  audio_stream_bridge #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .adc_data(adc_data), .adc_valid(adc_valid), .adc_ready(adc_ready),
    .core_rx_data(core_rx_data), .core_rx_valid(core_rx_valid), .core_rx_ready(core_rx_ready),
    .core_tx_data(core_tx_data), .core_tx_valid(core_tx_valid), .core_tx_ready(core_tx_ready),
    .dac_data(dac_data), .dac_valid(dac_valid), .dac_ready(dac_ready),
    .bypass(bypass), .mute(mute), .clear_status(clear_status),
    .overrun(overrun), .underrun(underrun), .dac_count(dac_count)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    adc_data = '0; adc_valid = '0; core_rx_ready = '0;
    core_tx_data = '0; core_tx_valid = '0; dac_ready = '0;
    bypass = '0; mute = '0; clear_status = 1'b0;
    step(); step();
    chk("rst_adc_ready", 64'(adc_ready), 64'h3);
    chk("rst_core_tx_ready", 64'(core_tx_ready), 64'h3);
    chk("rst_core_rx_valid", 64'(core_rx_valid), 64'h0);
    chk("rst_dac_valid", 64'(dac_valid), 64'h0);
    chk("rst_overrun", 64'(overrun), 64'h0);
    chk("rst_underrun", 64'(underrun), 64'h0);
    chk("rst_dac_count", 64'(dac_count), 64'h0);
    reset = 1'b0;

    // Normal RX flow on channel 0
    core_rx_ready = 2'b01; adc_valid = 2'b01;
    adc_data[31:0] = 32'h11; step();
    chk("rx_valid_11", 64'(core_rx_valid[0]), 64'h1);
    chk("rx_data_11", 64'(core_rx_data[31:0]), 64'h11);
    adc_data[31:0] = 32'h22; step();
    chk("rx_data_22", 64'(core_rx_data[31:0]), 64'h22);
    chk("adc_ready_flow", 64'(adc_ready[0]), 64'h1);
    adc_data[31:0] = 32'h33; step();
    chk("rx_data_33", 64'(core_rx_data[31:0]), 64'h33);
    adc_valid = '0; step();
    chk("rx_drained", 64'(core_rx_valid[0]), 64'h0);

    // Fill RX ch0 and overrun
    core_rx_ready = '0; adc_valid = 2'b01;
    adc_data[31:0] = 32'hA0; step();
    adc_data[31:0] = 32'hA1; step();
    adc_data[31:0] = 32'hA2; step();
    chk("adc_ready_3", 64'(adc_ready[0]), 64'h1);
    adc_data[31:0] = 32'hA3; step();
    chk("adc_ready_full", 64'(adc_ready[0]), 64'h0);
    chk("overrun_not_yet", 64'(overrun[0]), 64'h0);
    adc_data[31:0] = 32'hA4; step();
    chk("overrun_set", 64'(overrun[0]), 64'h1);
    chk("full_head", 64'(core_rx_data[31:0]), 64'hA0);
    adc_valid = '0; core_rx_ready = 2'b01; step();
    chk("adc_ready_after_pop", 64'(adc_ready[0]), 64'h1);
    chk("head_after_pop", 64'(core_rx_data[31:0]), 64'hA1);
    chk("overrun_sticky", 64'(overrun[0]), 64'h1);
    step(); step(); step();
    chk("rx_empty_again", 64'(core_rx_valid[0]), 64'h0);
    core_rx_ready = '0; clear_status = 1'b1; step();
    clear_status = 1'b0;
    chk("overrun_cleared", 64'(overrun), 64'h0);

    // Bypass on channel 1
    bypass = 2'b10; dac_ready = 2'b10; step();
    adc_data[63:32] = 32'hABCD; adc_valid = 2'b10; step();
    adc_valid = '0;
    chk("byp_rx_valid_a", 64'(core_rx_valid[1]), 64'h0);
    chk("byp_dac_valid_1cyc", 64'(dac_valid[1]), 64'h0);
    chk("byp_core_tx_ready", 64'(core_tx_ready[1]), 64'h0);
    step();
    chk("byp_dac_valid_2cyc", 64'(dac_valid[1]), 64'h1);
    chk("byp_dac_data", 64'(dac_data[63:32]), 64'hABCD);
    chk("byp_rx_valid_b", 64'(core_rx_valid[1]), 64'h0);
    step();
    chk("byp_dac_popped", 64'(dac_valid[1]), 64'h0);
    chk("count_ignores_ch1", 64'(dac_count), 64'h0);
    dac_ready = '0; bypass = '0;

    // Mute on channel 0
    core_tx_data[31:0] = 32'h55; core_tx_valid = 2'b01; mute = 2'b01; step();
    core_tx_valid = '0;
    chk("mute_dac_valid", 64'(dac_valid[0]), 64'h1);
    chk("mute_dac_data", 64'(dac_data[31:0]), 64'h0);
    dac_ready = 2'b01; step();
    dac_ready = '0; mute = '0;
    chk("mute_count", 64'(dac_count), 64'h1);
    chk("mute_popped", 64'(dac_valid[0]), 64'h0);
    chk("underrun_clean", 64'(underrun[0]), 64'h0);

    // Underrun and clear priority
    dac_ready = 2'b01; step();
    chk("underrun_set", 64'(underrun[0]), 64'h1);
    clear_status = 1'b1; step();
    chk("underrun_set_wins", 64'(underrun[0]), 64'h1);
    dac_ready = '0; step();
    clear_status = 1'b0;
    chk("underrun_cleared", 64'(underrun), 64'h0);
    chk("count_cleared", 64'(dac_count), 64'h0);

    // Clear and increment in the same cycle
    core_tx_data[31:0] = 32'h66; core_tx_valid = 2'b01; step();
    core_tx_valid = '0; dac_ready = 2'b01; clear_status = 1'b1; step();
    clear_status = 1'b0; dac_ready = '0;
    chk("clear_plus_inc", 64'(dac_count), 64'h1);

    // Stream to 0xFFFF: first edge only pushes, each later edge pops once
    core_tx_data[31:0] = 32'h77; core_tx_valid = 2'b01; dac_ready = 2'b01;
    for (int i = 0; i < 65535; i++) step();
    chk("count_ffff", 64'(dac_count), 64'hFFFF);
    core_tx_valid = '0; step();
    chk("count_wrap", 64'(dac_count), 64'h0);
    chk("wrap_tx_empty", 64'(dac_valid[0]), 64'h0);

    // Asynchronous reset mid-stream
    dac_ready = '0; core_tx_valid = 2'b01; step(); step();
    chk("pre_rst_dac_valid", 64'(dac_valid[0]), 64'h1);
    chk("pre_rst_underrun", 64'(underrun[0]), 64'h1);
    #2 reset = 1'b1;
    #1;
    chk("arst_dac_valid", 64'(dac_valid), 64'h0);
    chk("arst_adc_ready", 64'(adc_ready), 64'h3);
    chk("arst_underrun", 64'(underrun), 64'h0);
    chk("arst_overrun", 64'(overrun), 64'h0);
    chk("arst_count", 64'(dac_count), 64'h0);
    core_tx_valid = '0; step();
    reset = 1'b0; step();
    chk("post_rst_dac_valid", 64'(dac_valid), 64'h0);
    chk("post_rst_core_tx_ready", 64'(core_tx_ready), 64'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
